// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared grant encoding and default host wait bound for the DataMem arbiter
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_HOST} arb_gnt_t;
  localparam int DMEM_MAX_WAIT_DEF = 4;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core/host request ports and DataMem bus; master = requesters + memory, slave = arbiter
interface dmem_arbiter_if #(parameter int W = 8);
  logic         core_req, core_we, core_gnt, core_rvalid;
  logic [W-1:0] core_addr, core_wdata, core_rdata;
  logic         host_req, host_we, host_gnt, host_rvalid;
  logic [W-1:0] host_addr, host_wdata, host_rdata;
  logic         mem_we;
  logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  core_gnt, core_rdata, core_rvalid, host_gnt, host_rdata, host_rvalid,
    input  mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  host_req, host_we, host_addr, host_wdata, mem_rdata,
    output core_gnt, core_rdata, core_rvalid, host_gnt, host_rdata, host_rvalid,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_rd_port.sv
// arb_rd_port: per-port read-data register with a one-cycle rvalid pulse, loaded on a granted read
module arb_rd_port #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] rdata_o,
  output logic         rvalid_o
);
  logic [W-1:0] rdata_q;
  logic         rvalid_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= ld_i;
      if (ld_i) rdata_q <= d_i;
    end
  end
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core-priority arbiter for DataMem with bounded host starvation.
// Define DMEM_ARB_STATS_EN to add the saturating conflict_cnt output.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int W        = 8,
  parameter int MAX_WAIT = DMEM_MAX_WAIT_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  , output logic [15:0] conflict_cnt
`endif
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  arb_gnt_t   gnt;
  logic [3:0] wait_q, wait_d;
  // host wins outright when alone, or once it has been denied MAX_WAIT cycles in a row
  always_comb begin
    gnt = (bus.host_req && (!bus.core_req || wait_q == MW)) ? GNT_HOST :
          bus.core_req ? GNT_CORE : GNT_NONE;
    wait_d = (gnt == GNT_HOST) ? 4'd0 :
             (bus.host_req && wait_q != MW) ? wait_q + 4'd1 : wait_q;
  end
  assign bus.core_gnt  = gnt == GNT_CORE;
  assign bus.host_gnt  = gnt == GNT_HOST;
  assign bus.mem_we    = (gnt == GNT_HOST) ? bus.host_we    : (gnt == GNT_CORE) ? bus.core_we    : 1'b0;
  assign bus.mem_addr  = (gnt == GNT_HOST) ? bus.host_addr  : (gnt == GNT_CORE) ? bus.core_addr  : '0;
  assign bus.mem_wdata = (gnt == GNT_HOST) ? bus.host_wdata : (gnt == GNT_CORE) ? bus.core_wdata : '0;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) wait_q <= 4'd0;
    else          wait_q <= wait_d;
  end
  arb_rd_port #(.W(W)) u_core_rd (
    .clk(Clk), .rst_n(Reset_n), .ld_i(bus.core_gnt & ~bus.core_we), .d_i(bus.mem_rdata),
    .rdata_o(bus.core_rdata), .rvalid_o(bus.core_rvalid)
  );
  arb_rd_port #(.W(W)) u_host_rd (
    .clk(Clk), .rst_n(Reset_n), .ld_i(bus.host_gnt & ~bus.host_we), .d_i(bus.mem_rdata),
    .rdata_o(bus.host_rdata), .rvalid_o(bus.host_rvalid)
  );
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_q;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                                                   conflict_q <= 16'd0;
    else if (bus.core_req && bus.host_req && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
  end
  assign conflict_cnt = conflict_q;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a transaction-level reference model
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 4;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;
  dmem_arbiter_if #(.W(8)) bus ();
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif
  dmem_arbiter #(.W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
`ifdef DMEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  logic [7:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge Clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  int n_chk = 0, n_fail = 0;
  logic [7:0] ref_mem [256];
  int wait_n = 0, conf_n = 0;
  logic [7:0] exp_crd = 0, exp_hrd = 0;
  logic exp_crv = 0, exp_hrv = 0, m_cg = 0, m_hg = 0, obs_hg = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    wait_n = 0; conf_n = 0; exp_crd = 0; exp_hrd = 0; exp_crv = 0; exp_hrv = 0;
  endtask

  task automatic check_regs();
    chk("core_rvalid", bus.core_rvalid, exp_crv);
    chk("core_rdata", bus.core_rdata, exp_crd);
    chk("host_rvalid", bus.host_rvalid, exp_hrv);
    chk("host_rdata", bus.host_rdata, exp_hrd);
`ifdef DMEM_ARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, 16'(conf_n));
`endif
  endtask

  task automatic cycle(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                       input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd);
    bus.core_req = cr; bus.core_we = cw; bus.core_addr = ca; bus.core_wdata = cd;
    bus.host_req = hr; bus.host_we = hw; bus.host_addr = ha; bus.host_wdata = hd;
    #1;
    m_hg = hr && (!cr || wait_n == MAX_WAIT);
    m_cg = cr && !m_hg;
    obs_hg = bus.host_gnt;
    chk("core_gnt", bus.core_gnt, m_cg);
    chk("host_gnt", bus.host_gnt, m_hg);
    chk("mem_we", bus.mem_we, m_hg ? hw : m_cg ? cw : 1'b0);
    chk("mem_addr", bus.mem_addr, m_hg ? ha : m_cg ? ca : 8'h00);
    chk("mem_wdata", bus.mem_wdata, m_hg ? hd : m_cg ? cd : 8'h00);
    if (cr && hr && conf_n < 65535) conf_n++;
    if (m_hg) wait_n = 0;
    else if (hr && wait_n < MAX_WAIT) wait_n++;
    exp_crv = m_cg && !cw;
    if (exp_crv) exp_crd = ref_mem[ca];
    exp_hrv = m_hg && !hw;
    if (exp_hrv) exp_hrd = ref_mem[ha];
    if (m_cg && cw) ref_mem[ca] = cd;
    if (m_hg && hw) ref_mem[ha] = hd;
    @(posedge Clk); #1;
    check_regs();
  endtask

  task automatic idle();
    cycle(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    logic cp, hp, cwr, hwr;
    logic [7:0] ca, cd, ha, hd;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
    #12;
    check_regs();
    chk("rst_core_gnt", bus.core_gnt, 1'b0);
    chk("rst_host_gnt", bus.host_gnt, 1'b0);
    @(negedge Clk) Reset_n = 1'b1;
    // host preload then readback
    cycle(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5);
    cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    chk("host_readback", bus.host_rdata, 8'hA5);
    // continuous contention: host wins every fifth cycle
    for (int k = 0; k < 10; k++) begin
      cycle(1, 0, 8'(k), 8'h00, 1, 0, 8'(k + 32), 8'h00);
      chk("starve_pattern", obs_hg, (k == 4 || k == 9) ? 1'b1 : 1'b0);
    end
    // core read, write, read of the same address
    cycle(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
    chk("core_rv_c2", bus.core_rvalid, 1'b1);
    cycle(1, 1, 8'h03, 8'h5C, 0, 0, 8'h00, 8'h00);
    chk("core_rv_c3", bus.core_rvalid, 1'b0);
    cycle(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
    chk("core_rd_5c", bus.core_rdata, 8'h5C);
    idle();
    // reset mid-cycle right after a granted host read
    cycle(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00);
    #2 Reset_n = 1'b0;
    model_reset();
    #1;
    check_regs();
    bus.core_req = 1; bus.core_we = 0; bus.host_req = 1; bus.host_we = 0;
    #1;
    chk("rst_comb_core_gnt", bus.core_gnt, 1'b1);
    chk("rst_comb_host_gnt", bus.host_gnt, 1'b0);
    bus.core_req = 0; bus.host_req = 0;
    @(negedge Clk) Reset_n = 1'b1;
    for (int k = 0; k < 5; k++) idle();
    // randomized traffic; each requester holds its request until granted
    cp = 0; hp = 0; cwr = 0; hwr = 0; ca = 0; cd = 0; ha = 0; hd = 0;
    for (int k = 0; k < 300; k++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; cwr = 1'($urandom_range(0, 1)); ca = 8'($urandom_range(0, 15)); cd = 8'($urandom);
      end
      if (!hp && $urandom_range(0, 2) != 0) begin
        hp = 1; hwr = 1'($urandom_range(0, 1)); ha = 8'($urandom_range(0, 15)); hd = 8'($urandom);
      end
      cycle(cp, cwr, ca, cd, hp, hwr, ha, hd);
      if (m_cg) cp = 0;
      if (m_hg) hp = 0;
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    @(negedge Clk) Reset_n = 1'b0;
    model_reset();
    #1;
    check_regs();
    @(negedge Clk) Reset_n = 1'b1;
    for (int k = 0; k < 7; k++) cycle(1, 0, 8'(k), 8'h00, 1, 0, 8'(k), 8'h00);
    chk("conflict_7", conflict_cnt, 16'd7);
    idle();
    #2 Reset_n = 1'b0;
    #1;
    chk("conflict_rst", conflict_cnt, 16'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
